// File: rtl/motion_update_broadcast_arbiter_pkg.sv
// Shared types for the motion-update broadcast arbiter: FSM state encoding,
// default commit length and a helper that packs a destination cell ID.
package md_mu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPEN   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_COMMIT = 3'd4
  } mu_state_e;

  localparam int COMMIT_CYCLES_DEFAULT = 3;
  localparam int CELL_ID_WIDTH_DEFAULT = 4;

  // Packs a destination cell as {cell_x, cell_y, cell_z}, the order used on the bus.
  function automatic logic [3*CELL_ID_WIDTH_DEFAULT-1:0] cell_id_cat(
    input logic [CELL_ID_WIDTH_DEFAULT-1:0] cx,
    input logic [CELL_ID_WIDTH_DEFAULT-1:0] cy,
    input logic [CELL_ID_WIDTH_DEFAULT-1:0] cz
  );
    return {cx, cy, cz};
  endfunction

endpackage

// File: rtl/motion_update_broadcast_arbiter_if.sv
// Handshake and broadcast bus of the motion-update arbiter.
// Optional particle-count ports exist only when MU_BCAST_PARTICLE_COUNT_EN is defined.
interface motion_update_broadcast_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int NUM_REQ       = 4
`ifdef MU_BCAST_PARTICLE_COUNT_EN
  , parameter int CNT_WIDTH   = 16
`endif
) ();

  logic                                 start;
  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ*3*DATA_WIDTH-1:0]      req_data;
  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   req_dst_cell;
  logic [NUM_REQ-1:0]                   req_done;
  logic [NUM_REQ-1:0]                   req_ready;
  logic                                 motion_update_enable;
  logic [3*DATA_WIDTH-1:0]              out_data;
  logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell;
  logic                                 out_data_valid;
  logic                                 busy;
  logic                                 done;
`ifdef MU_BCAST_PARTICLE_COUNT_EN
  logic [CNT_WIDTH-1:0]                 expected_total;
  logic [CNT_WIDTH-1:0]                 bcast_count;
  logic                                 count_error;
`endif

  // Arbiter side.
  modport master (
    input  start, req_valid, req_data, req_dst_cell, req_done,
`ifdef MU_BCAST_PARTICLE_COUNT_EN
    input  expected_total,
    output bcast_count, count_error,
`endif
    output req_ready, motion_update_enable, out_data, out_data_dst_cell,
           out_data_valid, busy, done
  );

  // Engine / cache side.
  modport slave (
    output start, req_valid, req_data, req_dst_cell, req_done,
`ifdef MU_BCAST_PARTICLE_COUNT_EN
    output expected_total,
    input  bcast_count, count_error,
`endif
    input  req_ready, motion_update_enable, out_data, out_data_dst_cell,
           out_data_valid, busy, done
  );

endinterface

// File: rtl/motion_update_broadcast_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after the pointer and returns it as one-hot grant plus index.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
  output logic                       o_grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  // Candidate index for each priority slot: slot 0 is the pointer itself.
  logic [IDX_W-1:0] w_cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] w_sum;
      logic [IDX_W:0] w_wrap;
      assign w_sum       = {1'b0, i_ptr} + (IDX_W+1)'(gi);
      assign w_wrap      = w_sum - NUM_REQ_W;
      assign w_cand[gi]  = (w_sum >= NUM_REQ_W) ? w_wrap[IDX_W-1:0] : w_sum[IDX_W-1:0];
    end
  endgenerate

  // Scan slots from lowest priority up so the nearest request wins.
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_grant_idx   = w_cand[k];
        o_grant_valid = 1'b1;
      end
    end
    if (o_grant_valid) begin
      o_grant[o_grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/motion_update_broadcast_arbiter.sv
// Motion-update broadcast arbiter: frames the update window (OPEN, ACTIVE,
// DRAIN, COMMIT) and merges the engines onto one registered broadcast bus.
// Optional feature macro: MU_BCAST_PARTICLE_COUNT_EN (broadcast counter and
// count_error against expected_total).
module motion_update_broadcast_arbiter
  import md_mu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int NUM_REQ       = 4,
  parameter int COMMIT_CYCLES = COMMIT_CYCLES_DEFAULT
`ifdef MU_BCAST_PARTICLE_COUNT_EN
  , parameter int CNT_WIDTH   = 16
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  motion_update_broadcast_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PW    = 3 * DATA_WIDTH;
  localparam int CW    = 3 * CELL_ID_WIDTH;
  localparam int CC_W  = (COMMIT_CYCLES > 1) ? $clog2(COMMIT_CYCLES) : 1;
  localparam logic [CC_W-1:0]  CC_LOAD  = CC_W'(COMMIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  mu_state_e          r_state;
  mu_state_e          w_state_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [CC_W-1:0]    r_commit_cnt;
  logic [PW-1:0]      r_out_data;
  logic [CW-1:0]      r_out_dst;
  logic               r_out_valid;

  logic [PW-1:0]      w_req_data [NUM_REQ];
  logic [CW-1:0]      w_req_dst  [NUM_REQ];
  logic [NUM_REQ-1:0] w_req_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_valid;
  logic               w_active;
  logic               w_take;
  logic               w_all_finished;
  logic               w_commit_last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_req_data[gi] = bus.req_data[gi*PW +: PW];
      assign w_req_dst[gi]  = bus.req_dst_cell[gi*CW +: CW];
    end
  endgenerate

  // An engine that already reported done may not be granted.
  assign w_req_eligible = bus.req_valid & ~bus.req_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req         (w_req_eligible),
    .i_ptr         (r_ptr),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign w_active       = (r_state == ST_ACTIVE);
  assign w_take         = w_active & w_grant_valid;
  assign w_all_finished = (&bus.req_done) & ~(|bus.req_valid);
  assign w_commit_last  = (r_state == ST_COMMIT) && (r_commit_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Window sequencing: OPEN and DRAIN are single cycles, COMMIT ends on counter zero.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_state_next = ST_OPEN;
      ST_OPEN:   w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_all_finished) w_state_next = ST_DRAIN;
      ST_DRAIN:  w_state_next = ST_COMMIT;
      ST_COMMIT: if (r_commit_cnt == '0) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Round-robin pointer moves past the winner; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst)         r_ptr <= '0;
    else if (w_take) r_ptr <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + IDX_W'(1);
  end

  // Broadcast register stage; idle cycles present an all-zero bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_dst   <= '0;
    end else begin
      r_out_valid <= w_take;
      r_out_data  <= w_take ? w_req_data[w_grant_idx] : '0;
      r_out_dst   <= w_take ? w_req_dst[w_grant_idx]  : '0;
    end
  end

  // Commit countdown, loaded during DRAIN so COMMIT lasts exactly COMMIT_CYCLES.
  always_ff @(posedge clk) begin
    if (rst)                                              r_commit_cnt <= '0;
    else if (r_state == ST_DRAIN)                         r_commit_cnt <= CC_LOAD;
    else if (r_state == ST_COMMIT && r_commit_cnt != '0)  r_commit_cnt <= r_commit_cnt - CC_W'(1);
  end

  assign bus.req_ready            = w_active ? w_grant : '0;
  assign bus.motion_update_enable = (r_state == ST_OPEN) || (r_state == ST_ACTIVE) ||
                                    (r_state == ST_DRAIN);
  assign bus.busy                 = (r_state != ST_IDLE);
  assign bus.done                 = w_commit_last;
  assign bus.out_data             = r_out_data;
  assign bus.out_data_dst_cell    = r_out_dst;
  assign bus.out_data_valid       = r_out_valid;

`ifdef MU_BCAST_PARTICLE_COUNT_EN
  logic [CNT_WIDTH-1:0] r_bcast_count;
  logic                 r_count_error;
  logic                 w_start_accept;
  logic                 w_count_mismatch;

  assign w_start_accept   = (r_state == ST_IDLE) && bus.start;
  assign w_count_mismatch = (r_bcast_count != bus.expected_total);

  // Saturating count of broadcast particles in the current window.
  always_ff @(posedge clk) begin
    if (rst || w_start_accept)             r_bcast_count <= '0;
    else if (r_out_valid && ~&r_bcast_count) r_bcast_count <= r_bcast_count + CNT_WIDTH'(1);
  end

  // Sticky mismatch flag, latched when the window completes.
  always_ff @(posedge clk) begin
    if (rst || w_start_accept)                  r_count_error <= 1'b0;
    else if (w_commit_last && w_count_mismatch) r_count_error <= 1'b1;
  end

  assign bus.bcast_count = r_bcast_count;
  assign bus.count_error = r_count_error | (w_commit_last & w_count_mismatch);
`endif

endmodule

// File: tb/tb_motion_update_broadcast_arbiter.sv
// Scoreboard bench for motion_update_broadcast_arbiter with randomized engines.
module tb_motion_update_broadcast_arbiter;
  import md_mu_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int CIW = 4;
  localparam int CC  = 3;
  localparam int PW  = 3 * DW;
  localparam int CW  = 3 * CIW;

  typedef logic [PW+CW-1:0] item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_pop = 0;
  item_t q[$];
  item_t mon_exp;

  // Reference engine / arbiter state
  int            p = 0;
  int            left [N];
  int            pct  [N];
  bit            pend [N];
  logic [PW-1:0] cur_data [N];
  logic [CW-1:0] cur_dst  [N];
  bit            fix_en   [N];
  logic [CW-1:0] fix_dst  [N];
  int            waitc    [N];
  int            maxwait = 0;
  int            exp_total = 0;

  motion_update_broadcast_arbiter_if #(.DATA_WIDTH(DW), .CELL_ID_WIDTH(CIW), .NUM_REQ(N)) bus ();

  motion_update_broadcast_arbiter #(
    .DATA_WIDTH(DW), .CELL_ID_WIDTH(CIW), .NUM_REQ(N), .COMMIT_CYCLES(CC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Monitor: pop one expected broadcast per valid beat; idle beats must be zero.
  always @(negedge clk) begin
    if (bus.out_data_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bcast_unexpected got=%h exp=none", {bus.out_data, bus.out_data_dst_cell});
      end else begin
        mon_exp = q.pop_front();
        n_pop++;
        $display("bcast #%0d data=%h cell=%h", n_pop, bus.out_data, bus.out_data_dst_cell);
        chk("bcast_payload", {bus.out_data, bus.out_data_dst_cell}, mon_exp);
      end
    end else begin
      chk("idle_payload_zero", {bus.out_data_valid, bus.out_data, bus.out_data_dst_cell}, '0);
    end
  end

  task automatic setup(input int l0, input int l1, input int l2, input int l3, input int pc);
    left[0] = l0; left[1] = l1; left[2] = l2; left[3] = l3;
    exp_total = l0 + l1 + l2 + l3;
    for (int i = 0; i < N; i++) begin
      pct[i] = pc; pend[i] = 1'b0; fix_en[i] = 1'b0; waitc[i] = 0;
    end
    maxwait = 0;
  endtask

  // Engines present a particle with probability pct and hold it until granted.
  task automatic drive_engines();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && left[i] > 0 && $urandom_range(0, 99) < pct[i]) begin
        pend[i]     = 1'b1;
        cur_data[i] = {$urandom, $urandom, $urandom};
        cur_dst[i]  = fix_en[i] ? fix_dst[i] : CW'($urandom);
      end
      bus.req_valid[i]              = pend[i];
      bus.req_data[i*PW +: PW]      = cur_data[i];
      bus.req_dst_cell[i*CW +: CW]  = cur_dst[i];
      bus.req_done[i]               = (left[i] == 0);
    end
  endtask

  // One update window; abort_after>0 resets the DUT after that many grants.
  task automatic run_window(input int abort_after);
    int sent;
    int cyc;
    int g;
    bit fin;
    logic [N-1:0] er;
    sent = 0;
    cyc  = 0;
    fin  = 1'b0;
`ifdef MU_BCAST_PARTICLE_COUNT_EN
    bus.expected_total = exp_total[15:0];
`endif
    // IDLE cycle carrying start
    @(posedge clk); #1;
    bus.start = 1'b1;
    drive_engines();
    @(negedge clk);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_enable", bus.motion_update_enable, 1'b0);
    chk("idle_ready", bus.req_ready, '0);
    // OPEN
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive_engines();
    @(negedge clk);
    chk("open_enable", bus.motion_update_enable, 1'b1);
    chk("open_busy", bus.busy, 1'b1);
    chk("open_ready", bus.req_ready, '0);
    // ACTIVE
    while (!fin) begin
      @(posedge clk); #1;
      bus.start = ($urandom_range(0, 3) == 0);
      drive_engines();
      @(negedge clk);
      chk("active_enable", bus.motion_update_enable, 1'b1);
      fin = 1'b1;
      for (int i = 0; i < N; i++) if (left[i] != 0) fin = 1'b0;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (p + k) % N;
        if (g < 0 && pend[c]) g = c;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("grant", bus.req_ready, er);
      for (int i = 0; i < N; i++) begin
        if (pend[i] && i != g) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > maxwait) maxwait = waitc[i];
      end
      if (g >= 0) begin
        q.push_back({cur_data[g], cur_dst[g]});
        sent++;
        left[g]--;
        pend[g] = 1'b0;
        p = (g + 1) % N;
      end
      if (abort_after > 0 && sent == abort_after) begin
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin left[i] = 0; pend[i] = 1'b0; end
        bus.start = 1'b0;
        drive_engines();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_enable", bus.motion_update_enable, 1'b0);
        chk("rst_valid", bus.out_data_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        p = 0;
        chk("rst_sb_drained", q.size(), 0);
        return;
      end
      cyc++;
      if (cyc > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL active_timeout got=%0d exp=<=1000", cyc);
        summary_and_finish();
      end
    end
    // DRAIN
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive_engines();
    @(negedge clk);
    chk("drain_enable", bus.motion_update_enable, 1'b1);
    chk("drain_ready", bus.req_ready, '0);
    chk("drain_done", bus.done, 1'b0);
    // COMMIT; a start pulse here must be ignored
    for (int k = 0; k < CC; k++) begin
      @(posedge clk); #1;
      bus.start = (k == 0);
      @(negedge clk);
      chk("commit_enable", bus.motion_update_enable, 1'b0);
      chk("commit_busy", bus.busy, 1'b1);
      chk("commit_done", bus.done, (k == CC - 1));
`ifdef MU_BCAST_PARTICLE_COUNT_EN
      if (k == CC - 1) begin
        chk("bcast_count", bus.bcast_count, sent);
        chk("count_error_at_done", bus.count_error, (sent != exp_total));
      end
`endif
    end
    // back to IDLE
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("end_busy", bus.busy, 1'b0);
    chk("end_done", bus.done, 1'b0);
    chk("end_enable", bus.motion_update_enable, 1'b0);
    chk("sb_drained", q.size(), 0);
`ifdef MU_BCAST_PARTICLE_COUNT_EN
    chk("count_error_sticky", bus.count_error, (sent != exp_total));
`endif
  endtask

  initial begin
    int pop0;
    bus.start        = 1'b0;
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.req_dst_cell = '0;
    bus.req_done     = '1;
`ifdef MU_BCAST_PARTICLE_COUNT_EN
    bus.expected_total = '0;
`endif
    setup(0, 0, 0, 0, 100);
    repeat (3) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = '1;
    bus.req_done  = '0;
    @(negedge clk);
    chk("reset_enable", bus.motion_update_enable, 1'b0);
    chk("reset_valid", bus.out_data_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_ready", bus.req_ready, '0);
    chk("reset_data", {bus.out_data, bus.out_data_dst_cell}, '0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.req_done  = '1;

    // single engine, three particles to cell (3,2,4)
    setup(3, 0, 0, 0, 100);
    fix_en[0]  = 1'b1;
    fix_dst[0] = cell_id_cat(4'd3, 4'd2, 4'd4);
    pop0 = n_pop;
    run_window(0);
    chk("t1_bcasts", n_pop - pop0, 3);

    // all engines continuously valid
    setup(8, 8, 8, 8, 100);
    run_window(0);
    chk("t2_max_wait_le3", (maxwait <= N - 1), 1'b1);

    // sparse engines 1 and 3
    setup(0, 5, 0, 5, 100);
    run_window(0);

    // empty window
    setup(0, 0, 0, 0, 100);
    pop0 = n_pop;
    run_window(0);
    chk("t4_bcasts", n_pop - pop0, 0);

    // reset after two broadcasts, then a full window
    setup(6, 6, 0, 0, 100);
    run_window(2);
    setup(2, 1, 3, 1, 70);
    run_window(0);

`ifdef MU_BCAST_PARTICLE_COUNT_EN
    setup(4, 0, 0, 0, 100);
    exp_total = 5;
    run_window(0);
    setup(2, 3, 0, 0, 100);
    exp_total = 5;
    run_window(0);
`endif

    // randomized windows
    for (int w = 0; w < 6; w++) begin
      setup($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
            $urandom_range(0, 5), $urandom_range(30, 100));
      exp_total = exp_total + int'($urandom_range(0, 1));
      run_window(0);
    end

    summary_and_finish();
  end

  initial begin
    #2000000;
    n_cmp++;
    n_bad++;
    $display("FAIL global_timeout got=expired exp=finish");
    summary_and_finish();
  end

endmodule
